// File: rtl/bnn_sequencer_if.sv
// Host/layer-facing bus of the BNN sequencer: pixel stream in, phase bus and result out.
// master is the sequencer's view; slave is the host and layer-block view.
interface bnn_sequencer_if;
    logic             start;
    logic [7:0]       pix_byte;
    logic             pix_valid;
    logic             pix_ready;
    logic             l1_done;
    logic             l2_done;
    logic             l3_done;
    logic [3:0]       l3_class;
    logic [2:0]       state;
    logic             layer_clr;
    logic [27:0][27:0] pixels;
    logic [3:0]       class_out;
    logic             result_valid;
    logic             busy;
    logic             error;

    modport master (
        input  start, pix_byte, pix_valid, l1_done, l2_done, l3_done, l3_class,
        output pix_ready, state, layer_clr, pixels, class_out, result_valid, busy, error
    );

    modport slave (
        output start, pix_byte, pix_valid, l1_done, l2_done, l3_done, l3_class,
        input  pix_ready, state, layer_clr, pixels, class_out, result_valid, busy, error
    );
endinterface

// File: rtl/bnn_sequencer.sv
// Loads one 28x28 binary frame from a byte stream, then steps the phase bus through three layers.
// Define BNN_SEQ_WATCHDOG_EN to add a per-layer-phase timeout that sets the sticky error flag.
module bnn_sequencer #(
    parameter int unsigned NUM_BYTES   = 98,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input logic            clk,
    input logic            rst,
    bnn_sequencer_if.master bus
);
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned WDOG_W  = 13;
    localparam int unsigned FRAME_W = 784;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned CLASS_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_L1,
        S_L2,
        S_L3,
        S_RESULT
    } fsm_e;

    fsm_e               state_q;
    fsm_e               state_d;
    logic [CNT_W-1:0]   byte_cnt;
    logic [FRAME_W-1:0] frame;
    logic [PHASE_W-1:0] phase_q;
    logic [CLASS_W-1:0] class_q;
    logic               layer_clr_q;
    logic               result_valid_q;
    logic               busy_q;
    logic               error_q;

    logic               layer_clr_d;
    logic               result_valid_d;
    logic               frame_start_c;
    logic               byte_wr_c;
    logic               timeout_c;
    logic               wdog_hit_c;
    logic               layer_phase_c;

    // Phase-bus code seen by the layer blocks; RESULT looks like IDLE to them.
    function automatic logic [PHASE_W-1:0] phase_code(input fsm_e s);
        case (s)
            S_LOAD:  phase_code = 3'b001;
            S_L1:    phase_code = 3'b010;
            S_L2:    phase_code = 3'b011;
            S_L3:    phase_code = 3'b100;
            default: phase_code = 3'b000;
        endcase
    endfunction

    assign layer_phase_c = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);

`ifdef BNN_SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    // Restarts on every phase change so each layer gets a full budget.
    always_ff @(posedge clk) begin
        if (rst || !layer_phase_c || (state_d != state_q)) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    assign wdog_hit_c = layer_phase_c && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    // No timeout; the parameter stays referenced so both builds share one port list.
    assign wdog_hit_c = 1'b0 && (WDOG_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        layer_clr_d    = 1'b0;
        result_valid_d = 1'b0;
        frame_start_c  = 1'b0;
        byte_wr_c      = 1'b0;
        timeout_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d       = S_LOAD;
                    layer_clr_d   = 1'b1;
                    frame_start_c = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.pix_valid) begin
                    byte_wr_c = 1'b1;
                    if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
                        state_d = S_L1;
                    end
                end
            end
            S_L1: begin
                if (bus.l1_done) begin
                    state_d = S_L2;
                end else if (wdog_hit_c) begin
                    state_d   = S_IDLE;
                    timeout_c = 1'b1;
                end
            end
            S_L2: begin
                if (bus.l2_done) begin
                    state_d = S_L3;
                end else if (wdog_hit_c) begin
                    state_d   = S_IDLE;
                    timeout_c = 1'b1;
                end
            end
            S_L3: begin
                if (bus.l3_done) begin
                    state_d        = S_RESULT;
                    result_valid_d = 1'b1;
                end else if (wdog_hit_c) begin
                    state_d   = S_IDLE;
                    timeout_c = 1'b1;
                end
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the phase they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt       <= '0;
            frame          <= '0;
            phase_q        <= '0;
            class_q        <= '0;
            layer_clr_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            phase_q        <= phase_code(state_d);
            busy_q         <= (state_d != S_IDLE);
            layer_clr_q    <= layer_clr_d;
            result_valid_q <= result_valid_d;
            if (frame_start_c) begin
                byte_cnt <= '0;
            end else if (byte_wr_c) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (byte_wr_c) begin
                frame[{byte_cnt, 3'b000} +: 8] <= bus.pix_byte;
            end
            if (state_q == S_RESULT) begin
                class_q <= bus.l3_class;
            end
            if (frame_start_c) begin
                error_q <= 1'b0;
            end else if (timeout_c) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.pix_ready    = (state_q == S_LOAD);
    assign bus.state        = phase_q;
    assign bus.layer_clr    = layer_clr_q;
    assign bus.pixels       = frame;
    assign bus.class_out    = class_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_bnn_sequencer.sv
// Scoreboard bench for bnn_sequencer: random frames and layer latencies, results checked by a monitor.
module tb_bnn_sequencer;
    localparam int unsigned NB = 98;
    localparam int unsigned WD = 16;

    typedef logic [7:0] frame_t [NB];
    typedef struct {
        logic [3:0] cls;
        frame_t     bytes;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    frame_t     cur_frame;
    logic [3:0] last_cls = '0;

    bnn_sequencer_if bus();

    bnn_sequencer #(.NUM_BYTES(NB), .WDOG_CYCLES(WD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 64'(bus.state), 64'd0);
        chk({tag, "_pixels_zero"}, 64'(bus.pixels == '0), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_pix_ready"}, 64'(bus.pix_ready), 64'd0);
        chk({tag, "_layer_clr"}, 64'(bus.layer_clr), 64'd0);
        chk({tag, "_result_valid"}, 64'(bus.result_valid), 64'd0);
        chk({tag, "_error"}, 64'(bus.error), 64'd0);
        chk({tag, "_class_out"}, 64'(bus.class_out), 64'd0);
    endtask

    // Start a frame (with a junk byte alongside start) and stream it in, optionally stalling.
    task automatic load_frame(input frame_t f, input bit stall);
        int c0;
        cur_frame     = f;
        bus.l1_done   = 1'b0;
        bus.l2_done   = 1'b0;
        bus.l3_done   = 1'b0;
        bus.start     = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_byte  = ~f[0];
        c0 = cyc;
        tick();
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        chk("load_entry_state", 64'(bus.state), 64'd1);
        chk("layer_clr_pulse", 64'(bus.layer_clr), 64'd1);
        chk("pix_ready_load", 64'(bus.pix_ready), 64'd1);
        chk("error_cleared", 64'(bus.error), 64'd0);
        for (int k = 0; k < int'(NB); k++) begin
            if (stall && (k % 7 == 6)) begin
                bus.pix_valid = 1'b0;
                repeat (10) tick();
                if (k == 6) chk("stall_state", 64'(bus.state), 64'd1);
            end
            bus.pix_valid = 1'b1;
            bus.pix_byte  = f[k];
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.pix_byte  = 8'h00;
        chk("l1_entry_state", 64'(bus.state), 64'd2);
        chk("layer_clr_low", 64'(bus.layer_clr), 64'd0);
        if (!stall) chk("l1_entry_cycle", 64'(cyc - c0), 64'd99);
    endtask

    // Behave as the three layer blocks with the given latencies; expected result is queued first.
    task automatic handshake(input int d1, input int d2, input int d3, input logic [3:0] cls,
                             input bit stray);
        exp_t e;
        e.cls   = cls;
        e.bytes = cur_frame;
        exp_q.push_back(e);
        bus.l2_done = 1'b1;
        repeat (d1) tick();
        chk("l1_hold", 64'(bus.state), 64'd2);
        bus.l2_done = 1'b0;
        bus.l1_done = 1'b1;
        tick();
        chk("l2_entry", 64'(bus.state), 64'd3);
        for (int i = 0; i < d2; i++) begin
            bus.start = stray && (i == d2 / 2);
            tick();
            if (stray && (i == d2 / 2)) begin
                chk("stray_start_state", 64'(bus.state), 64'd3);
                chk("stray_start_clr", 64'(bus.layer_clr), 64'd0);
            end
        end
        bus.start   = 1'b0;
        bus.l2_done = 1'b1;
        tick();
        chk("l3_entry", 64'(bus.state), 64'd4);
        bus.l3_class = cls;
        repeat (d3) tick();
        bus.l3_done = 1'b1;
        tick();
        chk("result_state", 64'(bus.state), 64'd0);
        chk("result_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("idle_after_result", 64'(bus.busy), 64'd0);
        bus.l1_done  = 1'b0;
        bus.l2_done  = 1'b0;
        bus.l3_done  = 1'b0;
        bus.l3_class = ~cls;
        last_cls     = cls;
    endtask

    initial begin : monitor
        exp_t e;
        int   bad;
        forever begin
            @(posedge clk);
            #2;
            if (bus.result_valid === 1'b1) begin
                chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e   = exp_q.pop_front();
                    bad = 0;
                    for (int n = 0; n < 784; n++) begin
                        if (bus.pixels[n / 28][n % 28] !== e.bytes[n / 8][n % 8]) bad++;
                    end
                    chk("frame_pixels", 64'(bad), 64'd0);
                    @(posedge clk);
                    #2;
                    chk("class_out", 64'(bus.class_out), 64'(e.cls));
                    chk("result_pulse_width", 64'(bus.result_valid), 64'd0);
                end
            end
        end
    end

    initial begin : stim
        frame_t     f;
        int         n;
        logic [3:0] cls;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_byte  = '0;
        bus.l1_done   = 1'b0;
        bus.l2_done   = 1'b0;
        bus.l3_done   = 1'b0;
        bus.l3_class  = '0;
        repeat (2) tick();
        check_idle("reset");
        rst = 1'b0;

        // Reset in the middle of a load wipes the partial frame.
        for (int k = 0; k < int'(NB); k++) f[k] = 8'($urandom);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bus.pix_valid = 1'b1;
            bus.pix_byte  = f[k] | 8'h01;
            tick();
        end
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_idle("midload_rst");

        for (int k = 0; k < int'(NB); k++) f[k] = 8'hA5;
        load_frame(f, 1'b0);
        chk("row0_first_byte", 64'(bus.pixels[0][7:0]), 64'hA5);
        chk("last_pixel", 64'(bus.pixels[27][27]), 64'd1);
        handshake(50, 30, 20, 4'd7, 1'b1);

        load_frame(f, 1'b1);
        handshake(3, 0, 2, 4'd2, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < int'(NB); k++) f[k] = 8'($urandom);
            cls = 4'($urandom_range(0, 9));
            load_frame(f, r[0]);
            handshake(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 20)), cls, 1'b1);
        end

        for (int k = 0; k < int'(NB); k++) f[k] = 8'($urandom);
        cls = 4'($urandom_range(0, 9));
        load_frame(f, 1'b0);
`ifdef BNN_SEQ_WATCHDOG_EN
        bus.l1_done = 1'b1;
        tick();
        chk("wdog_l2_entry", 64'(bus.state), 64'd3);
        n = 0;
        while (bus.state == 3'b011 && n < 4 * int'(WD)) begin
            tick();
            n++;
        end
        chk("wdog_dwell", 64'(n), 64'(WD));
        chk("wdog_error", 64'(bus.error), 64'd1);
        chk("wdog_state", 64'(bus.state), 64'd0);
        chk("wdog_busy", 64'(bus.busy), 64'd0);
        chk("wdog_class_kept", 64'(bus.class_out), 64'(last_cls));
        load_frame(f, 1'b0);
        handshake(1, 1, 1, cls, 1'b0);
`else
        handshake(0, 40, 2, cls, 1'b0);
        chk("no_wdog_error", 64'(bus.error), 64'd0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
